mult_pipe: RTL

Parametrised, pipelined multiplier with valid/ready handshake. It is the sequential successor to the 8-bit combinational signed multiplier: operand width and pipeline depth are parameters, and backpressure stalls the pipeline. Without backpressure it accepts one operand pair per cycle. It is the multiply stage of the systolic processing element. It also serves as the drop-in reference multiplier for PE-level benches.

---
 rtl/mult_pipe_pkg.sv | 19 +
 rtl/mult_pipe_if.sv | 29 ++
 rtl/mult_pipe_stage.sv | 59 +++++
 rtl/mult_pipe.sv | 82 ++++++++
 4 files changed

// File: rtl/mult_pipe_pkg.sv
// Shared constants and row-slicing helpers for the pipelined multiplier.
package mult_pkg;

   localparam int unsigned MULT_MAX_WIDTH = 32;

   // Rows per stage: ceil((width+1)/stages).
   function automatic int unsigned mult_rows_per_stage(input int unsigned width,
                                                       input int unsigned stages);
      return (width + stages) / stages;
   endfunction

   // First partial-product row owned by slice k.
   function automatic int unsigned mult_row_lo(input int unsigned k,
                                               input int unsigned width,
                                               input int unsigned stages);
      return k * mult_rows_per_stage(width, stages);
   endfunction

endpackage

// File: rtl/mult_pipe_if.sv
// Operand/result handshake bundle for mult_pipe.
// MULT_PIPE_UNSIGNED_EN adds the per-transaction in_signed mode bit.
interface mult_pipe_if #(
   parameter int unsigned WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
`ifdef MULT_PIPE_UNSIGNED_EN
   logic               in_signed;
`endif
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_prod;

`ifdef MULT_PIPE_UNSIGNED_EN
   modport master (output in_valid, in_a, in_b, in_signed, out_ready,
                   input  in_ready, out_valid, out_prod);
   modport slave  (input  in_valid, in_a, in_b, in_signed, out_ready,
                   output in_ready, out_valid, out_prod);
`else
   modport master (output in_valid, in_a, in_b, out_ready,
                   input  in_ready, out_valid, out_prod);
   modport slave  (input  in_valid, in_a, in_b, out_ready,
                   output in_ready, out_valid, out_prod);
`endif

endinterface

// File: rtl/mult_pipe_stage.sv
// One pipeline stage: adds its slice of partial-product rows to the incoming
// partial sum and registers {valid, a_ext, b_ext, sum}; holds when not advancing.
module mult_pipe_stage
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 3,
   parameter int unsigned IDX    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 adv,
   input  logic                 prev_valid,
   input  logic [WIDTH:0]       prev_a,
   input  logic [WIDTH:0]       prev_b,
   input  logic [2*WIDTH+1:0]   prev_sum,
   output logic                 valid,
   output logic [WIDTH:0]       a,
   output logic [WIDTH:0]       b,
   output logic [2*WIDTH+1:0]   sum
);

   localparam int unsigned SW   = 2*WIDTH + 2;
   localparam int unsigned BW   = WIDTH + 1;
   localparam int          LO_I = int'(mult_row_lo(IDX, WIDTH, STAGES));
   localparam int          HI_I = LO_I + int'(mult_rows_per_stage(WIDTH, STAGES));

   logic [SW-1:0] a_sx;
   logic [SW-1:0] sum_c;

   assign a_sx = SW'($signed(prev_a));

   // Slice adder: rows LO..HI-1; row WIDTH carries weight -2^WIDTH.
   always_comb begin
      sum_c = prev_sum;
      for (int r = 0; r <= int'(WIDTH); r++) begin
         if (r >= LO_I && r < HI_I && (|(prev_b & (BW'(1) << r)))) begin
            if (r == int'(WIDTH)) sum_c = sum_c - (a_sx << r);
            else                  sum_c = sum_c + (a_sx << r);
         end
      end
   end

   // Stage register: load on advance, hold otherwise; reset drops the slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         sum   <= '0;
      end else if (adv) begin
         valid <= prev_valid;
         if (prev_valid) begin
            a   <= prev_a;
            b   <= prev_b;
            sum <= sum_c;
         end
      end
   end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined WIDTHxWIDTH multiplier with valid/ready handshake and collapsing
// bubbles. Optional macro MULT_PIPE_UNSIGNED_EN enables per-operation unsigned mode.
module mult_pipe
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 3
) (
   input  logic     clk,
   input  logic     rst,
   mult_pipe_if.slave bus
);

   localparam int unsigned SW = 2*WIDTH + 2;

   if (WIDTH < 2 || WIDTH > MULT_MAX_WIDTH || STAGES < 1 || STAGES > WIDTH + 1) begin : g_bad_cfg
      $error("mult_pipe: illegal WIDTH/STAGES");
   end

   logic [STAGES-1:0] v;
   logic [STAGES-1:0] adv;
   logic [WIDTH:0]    a_q [STAGES];
   logic [WIDTH:0]    b_q [STAGES];
   logic [SW-1:0]     s_q [STAGES];
   logic              sgn;
   logic [WIDTH:0]    a_ext;
   logic [WIDTH:0]    b_ext;
   logic              unused_bits;

`ifdef MULT_PIPE_UNSIGNED_EN
   assign sgn = bus.in_signed;
`else
   assign sgn = 1'b1;
`endif

   // Operand extension to WIDTH+1 bits, sign or zero by mode.
   assign a_ext = {sgn & bus.in_a[WIDTH-1], bus.in_a};
   assign b_ext = {sgn & bus.in_b[WIDTH-1], bus.in_b};

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Stage k advances if the output drains or any stage from k onward is empty.
      assign adv[k] = bus.out_ready | ~(&v[STAGES-1:k]);

      if (k == 0) begin : g_first
         mult_pipe_stage #(.WIDTH(WIDTH), .STAGES(STAGES), .IDX(k)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .adv        (adv[k]),
            .prev_valid (bus.in_valid),
            .prev_a     (a_ext),
            .prev_b     (b_ext),
            .prev_sum   (SW'(0)),
            .valid      (v[k]),
            .a          (a_q[k]),
            .b          (b_q[k]),
            .sum        (s_q[k])
         );
      end else begin : g_next
         mult_pipe_stage #(.WIDTH(WIDTH), .STAGES(STAGES), .IDX(k)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .adv        (adv[k]),
            .prev_valid (v[k-1]),
            .prev_a     (a_q[k-1]),
            .prev_b     (b_q[k-1]),
            .prev_sum   (s_q[k-1]),
            .valid      (v[k]),
            .a          (a_q[k]),
            .b          (b_q[k]),
            .sum        (s_q[k])
         );
      end
   end

   assign bus.in_ready  = adv[0] & ~rst;
   assign bus.out_valid = v[STAGES-1];
   assign bus.out_prod  = s_q[STAGES-1][2*WIDTH-1:0];

   // Operands and guard bits of the last stage are not needed downstream.
   assign unused_bits = ^{s_q[STAGES-1][SW-1:2*WIDTH], a_q[STAGES-1], b_q[STAGES-1]};

endmodule
